pci_req_sequencer: RTL

- Synthesizable, parametrised request/transaction sequencer for the PCI bus model.
- Replaces hard-coded per-device stimulus with a command FIFO.
- Each queued command makes one of NUM_DEV masters request the bus, present a target address, stream N data words, and repeat for T transactions.
- Sits between the bench (or on-chip test controller) and the master devices/arbiter of the PCI top module.

---
 rtl/pci_req_sequencer_pkg.sv | 36 +++
 rtl/pci_req_sequencer_if.sv | 44 ++++
 rtl/pci_req_sequencer_cmd_fifo.sv | 48 ++++
 rtl/pci_req_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pci_req_sequencer_pkg.sv
// Shared types and default constants for the PCI request sequencer.
// Optional watchdog is enabled by defining PCI_SEQ_TIMEOUT_EN.
package pci_seq_pkg;

  localparam int NUM_DEV_DEF        = 3;
  localparam int ADDR_W_DEF         = 32;
  localparam int DATA_W_DEF         = 32;
  localparam int CNT_W_DEF          = 4;
  localparam int FIFO_DEPTH_DEF     = 8;
  localparam int REQ_LEAD_DEF       = 3;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  // Index width for a device count; a single device still needs one bit.
  function automatic int dev_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEV_W_DEF = dev_w(NUM_DEV_DEF);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    DATA,
    WAIT_DONE
  } seq_state_e;

  typedef struct packed {
    logic [DEV_W_DEF-1:0]  dev;
    logic [ADDR_W_DEF-1:0] addr;
    logic [CNT_W_DEF-1:0]  words;
    logic [CNT_W_DEF-1:0]  trans;
    logic [DATA_W_DEF-1:0] data;
  } cmd_t;

endpackage

// File: rtl/pci_req_sequencer_if.sv
// Command and bus-side signals of the PCI request sequencer.
// master = command source / bus model side, slave = the sequencer.
interface pci_req_sequencer_if
  import pci_seq_pkg::*;
#(
  parameter int NUM_DEV = NUM_DEV_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
);
  localparam int DEV_W = dev_w(NUM_DEV);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [DEV_W-1:0]   cmd_dev;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [CNT_W-1:0]   cmd_words;
  logic [CNT_W-1:0]   cmd_trans;
  logic [DATA_W-1:0]  cmd_data;
  logic [NUM_DEV-1:0] force_request;
  logic [ADDR_W-1:0]  addr_to_contact;
  logic               addr_valid;
  logic [DATA_W-1:0]  wr_data;
  logic               data_valid;
  logic               data_ready;
  logic [NUM_DEV-1:0] txn_done;
  logic               busy;
  logic               err;

  modport master (
    output cmd_valid, cmd_dev, cmd_addr, cmd_words, cmd_trans, cmd_data,
           data_ready, txn_done,
    input  cmd_ready, force_request, addr_to_contact, addr_valid, wr_data,
           data_valid, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_dev, cmd_addr, cmd_words, cmd_trans, cmd_data,
           data_ready, txn_done,
    output cmd_ready, force_request, addr_to_contact, addr_valid, wr_data,
           data_valid, busy, err
  );

endinterface

// File: rtl/pci_req_sequencer_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible combinationally on o_dout.
// No push-on-pop bypass: a full FIFO refuses a push even while popping.
module pci_cmd_fifo
  import pci_seq_pkg::*;
#(
  parameter type T     = cmd_t,
  parameter int  DEPTH = FIFO_DEPTH_DEF
)(
  input  logic clck,
  input  logic rst,
  input  logic i_push,
  input  T     i_din,
  output logic o_full,
  input  logic i_pop,
  output T     o_dout,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);

  T           r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clck) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clck) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/pci_req_sequencer.sv
// Command-FIFO driven bus request sequencer for the PCI bus model masters.
// Define PCI_SEQ_TIMEOUT_EN to add the no-progress watchdog in DATA/WAIT_DONE.
//
// state     | meaning
// IDLE      | pop next command, validate it
// REQ       | optional 1-cycle gap, then force_request for REQ_LEAD cycles
// ADDR      | one-cycle address phase
// DATA      | stream words until word count reaches zero
// WAIT_DONE | wait for txn_done of the selected master
module pci_req_sequencer
  import pci_seq_pkg::*;
#(
  parameter int NUM_DEV        = NUM_DEV_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int REQ_LEAD       = REQ_LEAD_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
  input logic               clck,
  input logic               rst,
  pci_req_sequencer_if.slave bus
);
  localparam int                DEV_W     = dev_w(NUM_DEV);
  localparam int                LEAD_W    = (REQ_LEAD > 1) ? $clog2(REQ_LEAD) : 1;
  localparam logic [LEAD_W-1:0] LEAD_INIT = LEAD_W'(REQ_LEAD - 1);
  localparam logic [DEV_W:0]    DEV_LIM   = (DEV_W+1)'(NUM_DEV);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef struct packed {
    logic [DEV_W-1:0]  dev;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  words;
    logic [CNT_W-1:0]  trans;
    logic [DATA_W-1:0] data;
  } seq_cmd_t;

  seq_state_e        r_state, w_state_nxt;
  seq_cmd_t          r_cmd, w_head, w_fifo_din;
  logic [CNT_W-1:0]  r_word_cnt, w_word_cnt_nxt;
  logic [CNT_W-1:0]  r_trans_cnt, w_trans_cnt_nxt;
  logic [LEAD_W-1:0] r_lead_cnt, w_lead_cnt_nxt;
  logic              r_gap, w_gap_nxt;
  logic              r_err, w_err_nxt;
  logic              w_full, w_empty, w_push, w_pop;
  logic              w_hs, w_done, w_timeout, w_req_on;

  assign w_fifo_din = {bus.cmd_dev, bus.cmd_addr, bus.cmd_words, bus.cmd_trans, bus.cmd_data};
  assign w_push     = bus.cmd_valid && !w_full;
  assign w_hs       = (r_state == DATA) && bus.data_ready;
  assign w_done     = (r_state == WAIT_DONE) && bus.txn_done[r_cmd.dev];

  pci_cmd_fifo #(.T(seq_cmd_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clck    (clck),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_fifo_din),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_empty (w_empty)
  );

`ifdef PCI_SEQ_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] r_wdog;
  logic            w_wd_zone;

  assign w_wd_zone = (r_state == DATA) || (r_state == WAIT_DONE);

  always_ff @(posedge clck) begin
    if (rst || !w_wd_zone || w_hs || w_done) r_wdog <= WD_W'(TIMEOUT_CYCLES - 1);
    else if (r_wdog != '0)                   r_wdog <= r_wdog - WD_W'(1);
  end

  assign w_timeout = w_wd_zone && !w_hs && !w_done && (r_wdog == '0);
`else
  // Keeps the limit referenced when the watchdog is not built.
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clck) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_word_cnt  <= '0;
      r_trans_cnt <= '0;
      r_lead_cnt  <= '0;
      r_gap       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
      r_trans_cnt <= w_trans_cnt_nxt;
      r_lead_cnt  <= w_lead_cnt_nxt;
      r_gap       <= w_gap_nxt;
      r_err       <= w_err_nxt;
      if (w_pop) r_cmd <= w_head;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_word_cnt_nxt  = r_word_cnt;
    w_trans_cnt_nxt = r_trans_cnt;
    w_lead_cnt_nxt  = r_lead_cnt;
    w_gap_nxt       = r_gap;
    w_err_nxt       = r_err;
    w_pop           = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if ({1'b0, w_head.dev} >= DEV_LIM) begin
            w_err_nxt = 1'b1;
          end else if (w_head.trans != '0) begin
            w_state_nxt     = REQ;
            w_trans_cnt_nxt = w_head.trans;
            w_lead_cnt_nxt  = LEAD_INIT;
            w_gap_nxt       = 1'b0;
          end
        end
      end
      REQ: begin
        if (r_gap)                  w_gap_nxt      = 1'b0;
        else if (r_lead_cnt == '0)  w_state_nxt    = ADDR;
        else                        w_lead_cnt_nxt = r_lead_cnt - LEAD_W'(1);
      end
      ADDR: begin
        w_word_cnt_nxt = r_cmd.words;
        w_state_nxt    = (r_cmd.words == '0) ? WAIT_DONE : DATA;
      end
      DATA: begin
        if (w_hs) begin
          w_word_cnt_nxt = r_word_cnt - CNT_ONE;
          if (r_word_cnt == CNT_ONE) w_state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (w_done) begin
          w_trans_cnt_nxt = r_trans_cnt - CNT_ONE;
          if (r_trans_cnt == CNT_ONE) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt    = REQ;
            w_gap_nxt      = 1'b1;
            w_lead_cnt_nxt = LEAD_INIT;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = IDLE;
      w_err_nxt   = 1'b1;
    end
  end

  // Request is held from REQ through WAIT_DONE except the inter-transaction gap.
  assign w_req_on = (r_state != IDLE) && !((r_state == REQ) && r_gap);

  assign bus.force_request   = w_req_on ? ((NUM_DEV)'(1) << r_cmd.dev) : '0;
  assign bus.addr_valid      = (r_state == ADDR);
  assign bus.addr_to_contact = (r_state == ADDR) ? r_cmd.addr : '0;
  assign bus.data_valid      = (r_state == DATA);
  assign bus.wr_data         = (r_state == DATA) ? r_cmd.data : '0;
  assign bus.cmd_ready       = !w_full;
  assign bus.busy            = (r_state != IDLE) || !w_empty;
  assign bus.err             = r_err;

endmodule
